// File: rtl/cpu_defs.sv
// Shared definitions for the CPU pipeline control blocks: register constants,
// MDU state encoding and the default mult/div latency.
package cpu_defs;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MD_LATENCY_DEFAULT = 32;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_tracker.sv
// Tracks occupancy of the multiply/divide unit: a countdown from MD_LATENCY
// after each accepted mult/div, with a one-cycle done pulse on completion.
module md_tracker
    import cpu_defs::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done
);

    md_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // start is already qualified by the caller; it is only meaningful in IDLE
    // because a mult/div arriving while busy is held back by the stall.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (start) begin
                    state_next = MD_BUSY;
                    cnt_next   = CNT_W'(MD_LATENCY);
                end
            end
            MD_BUSY: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = MD_IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state_reg == MD_BUSY);
    assign done = done_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use and MDU-occupancy stalls, branch/jump
// flushes, and a free-running count of stalled cycles.
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_read,
    input  logic        id_branch_taken,
    input  logic        id_jump,
    input  logic        id_md_start,
    input  logic        id_md_read,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);

    logic        load_use;
    logic        md_hazard;
    logic        hazard_stall;
    logic        md_accept;
    logic [31:0] stall_count_reg;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    assign md_hazard    = md_busy && (id_md_read || id_md_start);
    assign hazard_stall = load_use || md_hazard;

    assign pc_stall    = hazard_stall;
    assign if_id_stall = hazard_stall;
    assign id_ex_flush = hazard_stall;
    assign id_ex_stall = 1'b0;

    // A redirect is deferred while stalled; the branch re-resolves afterwards.
    assign if_id_flush = (id_branch_taken || id_jump) && !hazard_stall;

    assign md_accept = id_md_start && !hazard_stall;

    md_tracker #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_tracker (
        .clock (clock),
        .reset (reset),
        .start (md_accept),
        .busy  (md_busy),
        .done  (md_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (hazard_stall) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the pipeline rules.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0;
    logic        id_branch_taken = 0, id_jump = 0, id_md_start = 0, id_md_read = 0;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        md_busy, md_done;
    logic [31:0] stall_count;

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rt           (ex_rt),
        .ex_mem_read     (ex_mem_read),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .id_md_start     (id_md_start),
        .id_md_read      (id_md_read),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_count     (stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        busy;
        logic        done;
        logic [31:0] count;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: MDU cycles remaining, pending done pulse, stall tally.
    int          md_left = 0;
    logic        md_pend = 0;
    logic [31:0] m_count = 0;

    function automatic logic model_stall();
        logic lu;
        logic mh;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        mh = (md_left > 0) && (id_md_read || id_md_start);
        return lu || mh;
    endfunction

    task automatic model_edge();
        logic st;
        st = model_stall();
        if (reset) begin
            md_left = 0;
            md_pend = 0;
            m_count = 0;
        end else begin
            md_pend = (md_left == 1);
            if (md_left > 0)
                md_left = md_left - 1;
            else if (id_md_start && !st)
                md_left = LAT;
            if (st)
                m_count = m_count + 1;
        end
    endtask

    int cyc = 0;

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] ert,
                        input logic mr, input logic br, input logic jp,
                        input logic ms, input logic mrd);
        exp_t e;
        @(posedge clock);
        model_edge();
        #1;
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_rt = ert; ex_mem_read = mr; id_branch_taken = br; id_jump = jp;
        id_md_start = ms; id_md_read = mrd;
        e.stall = model_stall();
        e.flush = (br || jp) && !e.stall;
        e.busy  = (md_left > 0);
        e.done  = md_pend;
        e.count = m_count;
        e.tag   = cyc;
        cyc++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, tag, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_stall", e.tag, {31'd0, pc_stall}, {31'd0, e.stall});
                chk("if_id_stall", e.tag, {31'd0, if_id_stall}, {31'd0, e.stall});
                chk("id_ex_flush", e.tag, {31'd0, id_ex_flush}, {31'd0, e.stall});
                chk("id_ex_stall", e.tag, {31'd0, id_ex_stall}, 32'd0);
                chk("if_id_flush", e.tag, {31'd0, if_id_flush}, {31'd0, e.flush});
                chk("md_busy", e.tag, {31'd0, md_busy}, {31'd0, e.busy});
                chk("md_done", e.tag, {31'd0, md_done}, {31'd0, e.done});
                chk("stall_count", e.tag, stall_count, e.count);
                $display("cycle %0d: stall=%0b flush=%0b busy=%0b done=%0b count=%0d",
                         e.tag, pc_stall, if_id_flush, md_busy, md_done, stall_count);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all inputs low: every output must be zero.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on rs, then clear.
        step(0, 8, 0, 1, 0, 8, 1, 0, 0, 0, 0);
        step(0, 8, 0, 1, 0, 8, 0, 0, 0, 0, 0);
        // $0 never hazards; unused rt does not hazard.
        step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 9, 0, 0, 9, 1, 0, 0, 0, 0);
        // Branch blocked by load-use, then redirect after, then jump alone.
        step(0, 3, 5, 1, 1, 5, 1, 1, 0, 0, 0);
        step(0, 3, 5, 1, 1, 5, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // MDU: start, then mfhi held until released.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < LAT + 1; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Back-to-back mult: second start held through busy.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < LAT + 1; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(LAT + 2);

        // Reset mid-BUSY with two cycles remaining.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(LAT - 2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(LAT + 2);

        // Random traffic with small register indices to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(2);

        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard control unit that generates the stall and flush controls consumed by the PC register, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, taken-branch/jump redirects and multiply/divide unit (MDU) occupancy.
- Holds a registered MDU busy state machine with a latency counter, so HI/LO readers and back-to-back mult/div stall until the result is ready.

Parameters:
- MD_LATENCY, 32, cycles an accepted mult/div occupies the MDU (valid range 2..63)
- CNT_W, 6, width of the MDU countdown counter; must hold MD_LATENCY

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs  in  5  ID-stage source register 1
- id_rt  in  5  ID-stage source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_rt  in  5  EX-stage load destination register
- ex_mem_read  in  1  EX instruction is a load (reg_src selects memory)
- id_branch_taken  in  1  ID branch resolved taken
- id_jump  in  1  ID instruction is j/jal/jr
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_read  in  1  ID instruction is mfhi/mflo
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  zero IF/ID
- id_ex_stall  out  1  hold ID/EX (tied 0 in this revision, kept for the interface)
- id_ex_flush  out  1  insert bubble into ID/EX
- md_busy  out  1  MDU occupied
- md_done  out  1  one-cycle pulse when the MDU result becomes valid
- stall_count  out  32  cycles on which hazard_stall was asserted, for performance monitoring

Behaviour:
- Internal terms:
  - load_use = ex_mem_read && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt))
  - md_hazard = md_busy && (id_md_read || id_md_start)
  - hazard_stall = load_use || md_hazard
- Combinational outputs, same cycle, from inputs plus registered state:
  - pc_stall = if_id_stall = id_ex_flush = hazard_stall
  - if_id_flush = (id_branch_taken || id_jump) && !hazard_stall
  - Stall wins over redirect: the branch is re-evaluated once the stall clears. No flush is issued while stalled.
  - id_ex_stall = 0
- Register $0 never creates a hazard.
- MDU FSM, states IDLE and BUSY:
  - IDLE -> BUSY on a clock edge with id_md_start && !hazard_stall; cnt <= MD_LATENCY.
  - In BUSY, cnt decrements each cycle. When cnt==1 at an edge, go to IDLE and set md_done <= 1 for exactly one cycle.
  - md_busy = (state==BUSY), so md_busy is high for exactly MD_LATENCY cycles after acceptance.
  - A new md_start arriving while BUSY stalls. It is accepted on the edge after busy clears, with no overlap.
  - mfhi/mflo in ID while busy stalls. It proceeds on the first cycle with md_busy=0, which is the same cycle md_done=1.
- stall_count increments on each edge where hazard_stall=1. It wraps at 2^32-1 -> 0.
- Reset (synchronous, takes effect at the next edge, including mid-BUSY):
  - state=IDLE, cnt=0, md_done=0, stall_count=0.
  - Combinational outputs follow from these values and the inputs. With all inputs 0, every output is 0.
- Latency: hazard outputs 0 cycles; md_done MD_LATENCY cycles after the accepting edge.

Decomposition:
- Shared package cpu_defs holds:
  - Register index constant REG_ZERO=5'd0
  - FSM state encoding MD_IDLE=1'b0 and MD_BUSY=1'b1
  - MD_LATENCY default
- One natural sub-module, md_tracker, containing the FSM, counter and md_done pulse. hazard_ctrl contains the detection logic and stall_count.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> pc_stall=if_id_stall=id_ex_flush=1 that cycle. With ex_mem_read=0 on the next cycle, all stall outputs=0 and stall_count=1.
- $0 and unused operand: ex_rt=0, id_rs=0 -> no stall. Also ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Branch vs stall: id_branch_taken=1 with load_use -> if_id_flush=0 and stall asserted. The cycle after the load clears, id_branch_taken=1 -> if_id_flush=1. id_jump alone -> if_id_flush=1.
- MDU timing, MD_LATENCY=4: id_md_start for one cycle.
  - md_busy=1 for cycles 1-4 after the edge.
  - md_done=1 only in cycle 5, with md_busy=0.
  - id_md_read held from cycle 1 stalls cycles 1-4 and is released in cycle 5; stall_count=4.
- Back-to-back mult: second id_md_start held while busy -> stalls until busy clears, then is accepted; md_busy re-asserts on the next cycle for 4 cycles.
- Reset mid-BUSY: assert reset with cnt=2 -> after the edge md_busy=0, md_done=0, stall_count=0, and no md_done pulse follows.
